// File: rtl/n8by4_sequential_divider_if.sv
// Handshake and operand/result bus for the 8-by-4 sequential divider.
// The master issues divisions; the slave (the divider) returns results.
interface n8by4_sequential_divider_if;
    logic       start;
    logic [7:0] p7_p0;
    logic [3:0] y3_y0;
    logic       ready;
    logic       valid;
    logic       err;
    logic [3:0] x3_x0;
    logic [3:0] c3_c0;

    modport master (
        output start, p7_p0, y3_y0,
        input  ready, valid, err, x3_x0, c3_c0
    );

    modport slave (
        input  start, p7_p0, y3_y0,
        output ready, valid, err, x3_x0, c3_c0
    );
endinterface

// File: rtl/n8by4_sequential_divider.sv
// Restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per
// clock. Finds x, c with p = x*y + c and c < y. Operations whose quotient
// cannot fit in 4 bits (y == 0 or p[7:4] >= y) are flagged with err and skip
// the iteration entirely.
module n8by4_sequential_divider (
    input  logic                          clock,
    input  logic                          reset_,
    n8by4_sequential_divider_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Iteration state
    logic [4:0] rem;        // partial remainder, always < dvsr while running
    logic [3:0] low;        // dividend bits still to be shifted in
    logic [3:0] dvsr;       // divisor latched at accept
    logic [3:0] quo;        // quotient bits developed so far
    logic [1:0] cnt;        // index of the bit processed this step

    // Result registers, held until the next operation completes
    logic [3:0] x_q;
    logic [3:0] c_q;
    logic       err_q;

    // Step datapath
    logic       accept;
    logic       ovf;
    logic       last;
    logic [4:0] trial;
    logic       q_bit;
    logic [4:0] rem_step;

    // Accept decode, overflow screen and one restoring step
    always_comb begin
        accept   = (state == IDLE) && bus.start;
        ovf      = (bus.y3_y0 == 4'd0) || (bus.p7_p0[7:4] >= bus.y3_y0);
        last     = (cnt == 2'd0);
        // rem < dvsr <= 15, so shifting in one bit gives at most 29
        trial    = {rem[3:0], low[cnt]};
        q_bit    = (trial >= {1'b0, dvsr});
        rem_step = q_bit ? (trial - {1'b0, dvsr}) : trial;
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ovf ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, iteration and result capture
    always_ff @(posedge clock) begin
        if (!reset_) begin
            rem   <= 5'd0;
            low   <= 4'd0;
            dvsr  <= 4'd0;
            quo   <= 4'd0;
            cnt   <= 2'd0;
            x_q   <= 4'd0;
            c_q   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvsr <= bus.y3_y0;
                        low  <= bus.p7_p0[3:0];
                        rem  <= {1'b0, bus.p7_p0[7:4]};
                        quo  <= 4'd0;
                        if (ovf) begin
                            // Quotient would need more than 4 bits
                            err_q <= 1'b1;
                            x_q   <= 4'd0;
                            c_q   <= 4'd0;
                        end else begin
                            cnt <= 2'd3;
                        end
                    end
                end
                RUN: begin
                    rem      <= rem_step;
                    quo[cnt] <= q_bit;
                    cnt      <= cnt - 2'd1;
                    if (last) begin
                        // quo[0] is being written this edge; take it from q_bit
                        x_q   <= {quo[3:1], q_bit};
                        c_q   <= rem_step[3:0];
                        err_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.valid = (state == DONE);
    assign bus.err   = err_q;
    assign bus.x3_x0 = x_q;
    assign bus.c3_c0 = c_q;

    // The restoring step relies on the partial remainder staying below the
    // divisor; the overflow screen at accept is what guarantees it.
    rem_below_divisor: assert property (
        @(posedge clock) disable iff (!reset_)
        (state == RUN) |-> (rem < {1'b0, dvsr})
    );

endmodule

// File: tb/tb_n8by4_sequential_divider.sv
// Scoreboard bench for the 8-by-4 sequential divider: the driver pushes the
// expected result and the valid cycle at each accept; a monitor pops and
// compares on every valid pulse.
module tb_n8by4_sequential_divider;

    logic clock  = 1'b0;
    logic reset_ = 1'b0;

    always #5 clock = ~clock;

    n8by4_sequential_divider_if bus ();

    n8by4_sequential_divider dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] c;
        logic       err;
        int         vcyc;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (bus.valid) begin
            if (sbq.size() == 0) begin
                chk($sformatf("spurious_valid_cyc%0d", cyc), 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_x"},       int'(bus.x3_x0), int'(mon_e.x));
                chk({mon_e.name, "_c"},       int'(bus.c3_c0), int'(mon_e.c));
                chk({mon_e.name, "_err"},     int'(bus.err),   int'(mon_e.err));
                chk({mon_e.name, "_latency"}, cyc,             mon_e.vcyc);
            end
        end
    end

    // Wait for ready, present operands, record the expectation for the accept edge
    task automatic issue(input string name, input logic [7:0] p, input logic [3:0] y,
                         input logic [3:0] ex, input logic [3:0] ec, input logic ee,
                         input bit push, input bit hold, output int acc);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.ready && n < 50);
        if (!bus.ready) begin
            chk({name, "_ready_timeout"}, 0, 1);
            acc = -1;
            return;
        end
        bus.start = 1'b1;
        bus.p7_p0 = p;
        bus.y3_y0 = y;
        acc = cyc + 1;
        if (push) sbq.push_back('{x: ex, c: ec, err: ee, vcyc: acc + (ee ? 0 : 4), name: name});
        @(posedge clock);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("drain_outstanding", sbq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, acc1, acc2;
        logic [7:0] p;
        logic [3:0] y, ex, ec;
        logic       ee;

        bus.start = 1'b0;
        bus.p7_p0 = 8'd0;
        bus.y3_y0 = 4'd0;
        reset_    = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_ready", int'(bus.ready), 1);
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_err",   int'(bus.err),   0);
        chk("reset_x",     int'(bus.x3_x0), 0);
        chk("reset_c",     int'(bus.c3_c0), 0);
        reset_ = 1'b1;

        // 100 = 14*7 + 2; ready stays low while iterating
        issue("d100_7", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1, 0, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("d100_7_busy%0d", i), int'(bus.ready), 0);
        end
        issue("d225_15", 8'd225, 4'd15, 4'd15, 4'd0, 1'b0, 1, 0, acc);
        issue("d0_1",    8'd0,   4'd1,  4'd0,  4'd0, 1'b0, 1, 0, acc);
        issue("d255_15", 8'd255, 4'd15, 4'd0,  4'd0, 1'b1, 1, 0, acc);
        issue("d5_0",    8'd5,   4'd0,  4'd0,  4'd0, 1'b1, 1, 0, acc);
        issue("d100_7b", 8'd100, 4'd7,  4'd14, 4'd2, 1'b0, 1, 0, acc);
        drain();

        // Abort mid-run: no valid pulse, results cleared
        issue("abort", 8'd100, 4'd7, 4'd0, 4'd0, 1'b0, 0, 0, acc);
        @(negedge clock);
        @(negedge clock);
        reset_ = 1'b0;
        @(negedge clock);
        chk("abort_ready", int'(bus.ready), 1);
        chk("abort_valid", int'(bus.valid), 0);
        chk("abort_x",     int'(bus.x3_x0), 0);
        chk("abort_c",     int'(bus.c3_c0), 0);
        reset_ = 1'b1;
        issue("post_abort", 8'd225, 4'd15, 4'd15, 4'd0, 1'b0, 1, 0, acc);
        drain();

        // start held high, operands changed mid-run
        issue("hold1", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1, 1, acc1);
        @(negedge clock);
        @(negedge clock);
        bus.p7_p0 = 8'd225;
        bus.y3_y0 = 4'd15;
        issue("hold2", 8'd225, 4'd15, 4'd15, 4'd0, 1'b0, 1, 0, acc2);
        chk("back_to_back_accept_edge", acc2, acc1 + 6);
        drain();

        // Every input pair
        for (int pi = 0; pi < 256; pi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                p = pi[7:0];
                y = yi[3:0];
                if (y == 4'd0 || p[7:4] >= y) begin
                    ex = 4'd0; ec = 4'd0; ee = 1'b1;
                end else begin
                    ex = 4'(pi / yi); ec = 4'(pi % yi); ee = 1'b0;
                end
                issue($sformatf("sweep_p%0d_y%0d", pi, yi), p, y, ex, ec, ee, 1, 0, acc);
            end
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
